// File: rtl/ysyx_25030085_lsu.sv
// ysyx_25030085_lsu: multi-cycle load/store unit, one word-aligned memory access per request
//   clk_i/rst_ni        : clock, asynchronous active-low reset
//   req_*_i, req_ready_o: request from execute (wen, funct3, byte addr, store data, rd)
//   mem_req_*           : word-aligned memory request with byte-lane mask and lane-aligned data
//   mem_resp_*          : memory response (load word or store ack)
//   done_o              : one-cycle completion pulse; done_rd_o/load_data_o/err_o hold until next completion
module ysyx_25030085_lsu #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wen_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_resp_ready_o,
    output logic        done_o,
    output logic [4:0]  done_rd_o,
    output logic [31:0] load_data_o,
    output logic        err_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    state_t      state_q, state_d;
    logic        wen_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic [4:0]  done_rd_q, done_rd_d;
    logic        err_q, err_d;
    logic        accept, legal, misaligned, req_err, wd_hit;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ext;

    // req_ready stays low while reset is held so nothing is accepted during reset
    assign req_ready_o = (state_q == S_IDLE) && rst_ni;
    assign accept      = req_valid_i && req_ready_o;
    assign legal       = req_wen_i ? (req_funct3_i inside {3'b000, 3'b001, 3'b010})
                                   : (req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign misaligned  = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                         (req_funct3_i == 3'b010 && req_addr_i[1:0] != 2'b00);
    assign req_err     = !legal || misaligned;
    // fires on the cycle whose increment would make the count reach TIMEOUT
    assign wd_hit      = (TIMEOUT != 8'd0) && (cnt_q + 8'd1 == TIMEOUT);

    assign byte_v = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    assign half_v = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    assign ext    = f3_q == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                    f3_q == 3'b001 ? {{16{half_v[15]}}, half_v} :
                    f3_q == 3'b100 ? {24'd0, byte_v} :
                    f3_q == 3'b101 ? {16'd0, half_v} : mem_rdata_i;

    assign mem_req_valid_o  = state_q == S_REQ;
    assign mem_resp_ready_o = state_q == S_WAIT;
    assign done_o           = state_q == S_DONE;
    assign mem_addr_o       = {addr_q[31:2], 2'b00};
    assign mem_wen_o        = wen_q;
    assign mem_wmask_o      = !wen_q ? 4'b0000 :
                              f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                              f3_q[1:0] == 2'b01 ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    assign mem_wdata_o      = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                              f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign done_rd_o        = done_rd_q;
    assign load_data_o      = load_data_q;
    assign err_o            = err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        done_rd_d   = done_rd_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: if (accept) begin
                cnt_d   = 8'd0;
                state_d = req_err ? S_DONE : S_REQ;
                if (req_err) begin
                    err_d       = 1'b1;
                    load_data_d = 32'd0;
                    done_rd_d   = req_wen_i ? 5'd0 : req_rd_i;
                end
            end
            // a timeout in REQ wins over a same-cycle handshake; any later response is dropped in IDLE
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (wd_hit) begin
                    state_d     = S_DONE;
                    err_d       = 1'b1;
                    load_data_d = 32'd0;
                    done_rd_d   = wen_q ? 5'd0 : rd_q;
                end else if (mem_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_resp_valid_i) begin
                    state_d     = S_DONE;
                    err_d       = 1'b0;
                    load_data_d = wen_q ? 32'd0 : ext;
                    done_rd_d   = wen_q ? 5'd0 : rd_q;
                end else if (wd_hit) begin
                    state_d     = S_DONE;
                    err_d       = 1'b1;
                    load_data_d = 32'd0;
                    done_rd_d   = wen_q ? 5'd0 : rd_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            wen_q       <= 1'b0;
            f3_q        <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rd_q        <= 5'd0;
            load_data_q <= 32'd0;
            done_rd_q   <= 5'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            done_rd_q   <= done_rd_d;
            err_q       <= err_d;
            if (accept) begin
                wen_q   <= req_wen_i;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                rd_q    <= req_rd_i;
            end
        end
    end
endmodule

// File: doc/ysyx_25030085_lsu.md
# ysyx_25030085_lsu

Multi-cycle load/store unit for the NPC core. It sits between the execute stage (address from the ALU result, store data from rs2) and the register file's memory write-back path (MemtoReg = 2'b01). It converts one load/store request into a single word-aligned memory transaction with byte-lane masking. It returns the sign- or zero-extended load result together with the destination register index.

## Interface
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before the access is aborted with an error; 8-bit counter range, value 0 disables the watchdog.
- clk  in  1  core clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- req_valid  in  1  execute stage presents a load/store.
- req_ready  out  1  high only in IDLE; request accepted on req_valid && req_ready.
- req_wen  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  effective byte address (ALU result).
- req_wdata  in  32  store data (rs2 value).
- req_rd  in  5  destination register for loads.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  32  {req_addr[31:2], 2'b00}.
- mem_wen  out  1  store request.
- mem_wmask  out  4  byte-lane enable, 0 for loads.
- mem_wdata  out  32  lane-aligned store data.
- mem_resp_valid  in  1  memory response (load data or store ack).
- mem_rdata  in  32  load word.
- mem_resp_ready  out  1  high only in WAIT.
- done  out  1  one-cycle completion pulse.
- done_rd  out  5  rd of the completed access (0 for stores).
- load_data  out  32  extended load result; 0 for stores and errors.
- err  out  1  valid with done: misaligned, illegal funct3, or timeout.

## Operation
- FSM: IDLE -> REQ -> WAIT -> DONE -> IDLE; IDLE -> DONE on a detected error.
- On accept, register wen, funct3, addr, wdata, rd.
- Error check happens at accept:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]!=0 is misaligned.
  - funct3 not in {000,001,010,100,101} (loads) or not in {000,001,010} (stores) is illegal.
  - On any error: no memory transaction, next state DONE with err=1.
- Store lanes:
  - SB: mask = 4'b0001<<addr[1:0], data = {4{wdata[7:0]}}.
  - SH: mask = 4'b0011<<(2*addr[1]), data = {2{wdata[15:0]}}.
  - SW: mask = 4'b1111, data = wdata.
- Load extract:
  - B/BU: byte = rdata[8*addr[1:0]+:8].
  - H/HU: half = rdata[16*addr[1]+:16].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- REQ: mem_req_valid=1; mem_addr/wen/wmask/wdata are stable until mem_req_ready; leave to WAIT on handshake.
- WAIT: mem_resp_ready=1; on mem_resp_valid capture the extracted result, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Hold: load_data, done_rd and err hold their values after done until the next DONE.
- Watchdog:
  - 8-bit counter clears on accept and increments each cycle in REQ/WAIT.
  - When the count reaches TIMEOUT (TIMEOUT≠0): go to DONE with err=1 and load_data=0, dropping mem_req_valid.
  - A late response arriving in IDLE is ignored (mem_resp_ready=0).
- Reset (rst=0, any state): immediately IDLE; all outputs 0 except req_ready=1 once rst deasserts. An in-flight memory transaction is abandoned.

## Timing
- Accept at cycle N; mem_req_valid rises at N+1.
- Best case: mem_req_ready at N+1 and mem_resp_valid at N+2 gives done at N+3.
- A response is never sampled in the same cycle as the request handshake.
- Error path: accept at N gives done/err at N+1.
- req_ready is low from N+1 through the DONE cycle; a new request can be accepted the cycle after done.
- Back-pressure: each cycle of mem_req_ready=0 or mem_resp_valid=0 adds one cycle.

## Test plan
- LW from 0x80000004, mem_rdata=0xDEADBEEF, ready/resp immediate, rd=5 -> done at N+3, load_data=0xDEADBEEF, done_rd=5, err=0, mem_addr=0x80000004.
- LB from 0x80000003, rdata=0x80FF7F01 -> load_data=0xFFFFFF80; same access as LBU -> 0x00000080; LH at offset 2 -> 0xFFFF80FF.
- SH addr 0x80000102, wdata=0x1234ABCD -> mem_addr=0x80000100, wmask=4'b1100, wdata[31:16]=0xABCD, load_data=0, done_rd=0.
- LW at 0x80000002 -> no mem_req_valid, done+err at N+1; funct3=3'b011 behaves the same.
- TIMEOUT=4 with mem_req_ready held 0 -> mem_req_valid drops and done+err assert 4 cycles after REQ entry; a later mem_resp_valid is ignored.
- rst pulled low in WAIT -> same cycle: mem_resp_ready=0, done=0; after release req_ready=1 and the next LW completes normally.
